irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized button must differ from its debounced state before that state changes; legal range 1..255.
REQ-002 Parameter IRQ_ID_BASE, default 5'd16: IRQ_ID reported for line 0; line i reports IRQ_ID_BASE+i; IRQ_ID_BASE+3 SHALL NOT exceed 31.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RESN  input  1  asynchronous, active-low reset.
REQ-005 BUTTON  input  4  raw asynchronous board buttons, active high.
REQ-006 ENABLE  input  4  per-line interrupt enable, synchronous to CLK.
REQ-007 IRQ  output  1  level-sensitive interrupt request to the core.
REQ-008 IRQ_ID  output  5  ID of the presented interrupt, valid while IRQ=1.
REQ-009 IRQ_ACK  input  1  one-cycle acknowledge pulse from the core.
REQ-010 IRQ_ACK_ID  input  5  ID being acknowledged, sampled with IRQ_ACK.
REQ-011 PENDING  output  4  pending bit per line.
REQ-012 OVERRUN  output  4  sticky flag: a new event arrived on a line that was already pending.

Function
REQ-013 Each BUTTON bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: a per-line counter SHALL reset to 0 whenever the synchronized value equals the debounced value. The debounced value SHALL take the synchronized value on the edge completing DEBOUNCE_CYCLES consecutive differing samples.
REQ-015 A 0->1 transition of a debounced line with ENABLE[i]=1 SHALL set PENDING[i] on the following edge. Falling edges and disabled lines SHALL never set PENDING.
REQ-016 Latency: with BUTTON[i] held high from sampling edge 0, IRQ SHALL rise after edge DEBOUNCE_CYCLES+3 when the controller is idle. With the default value this is edge 7.
REQ-017 The controller SHALL be an FSM with two states. IDLE: IRQ=0. ASSERT: IRQ=1, IRQ_ID registered.
REQ-018 IDLE->ASSERT on any edge with PENDING&ENABLE nonzero. The line is chosen by fixed priority, lowest index first, and IRQ_ID is loaded with IRQ_ID_BASE+index.
REQ-019 In ASSERT, IRQ_ID SHALL remain constant until acknowledged, even if a higher-priority line becomes pending.
REQ-020 ASSERT->IDLE on an edge with IRQ_ACK=1 and IRQ_ACK_ID==IRQ_ID; on the same edge the corresponding PENDING bit and OVERRUN bit SHALL be cleared.
REQ-021 IRQ_ACK with a mismatched ID, or IRQ_ACK while in IDLE, SHALL be ignored with no state change.
REQ-022 After an acknowledge, IRQ SHALL be 0 for at least one cycle; re-arbitration happens on the next edge.
REQ-023 Set/clear collision: if a new event on line i coincides with the acknowledge of line i, PENDING[i] SHALL remain 1 (set wins) and OVERRUN[i] SHALL be 0.
REQ-024 A new event on line i while PENDING[i]=1 and no clear is in progress SHALL set OVERRUN[i]; events SHALL NOT be counted beyond that.
REQ-025 If ENABLE[i] drops while line i is presented in ASSERT, the request SHALL stay asserted until acknowledged. Disabled pending lines SHALL NOT win arbitration in IDLE.
REQ-026 All outputs SHALL be driven directly from flops.

Reset
REQ-027 With RESN=0, asynchronously:
- IRQ=0, IRQ_ID=0, PENDING=0, OVERRUN=0
- FSM=IDLE
- synchronizers, debounced values and counters = 0
REQ-028 Reset asserted mid-ASSERT SHALL drop IRQ immediately. After release, a button still held high SHALL be treated as a new rising event and reported again after the full REQ-016 latency.

Verification
REQ-029 BUTTON=4'b0001 held, ENABLE=4'hF, default parameters -> IRQ=1, IRQ_ID=16 after edge 7; ack with IRQ_ACK_ID=16 -> IRQ=0 and PENDING=0 on the next cycle.
REQ-030 BUTTON high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> IRQ never rises, PENDING stays 0.
REQ-031 Lines 2 and 1 pending simultaneously -> IRQ_ID=17; ack 17 -> IRQ=0 for one cycle, then IRQ_ID=18; ack 18 -> IRQ=0, PENDING=0.
REQ-032 IRQ_ID=18 presented, line 0 becomes pending, and an ack with ID 16 is issued -> IRQ_ID stays 18, PENDING stays 4'b0101.
REQ-033 Second press of line 3 while PENDING[3]=1 -> OVERRUN=4'b1000; ack 19 -> OVERRUN=0, PENDING[3]=0.
REQ-034 RESN pulsed low while IRQ=1 with button held -> IRQ=0 during reset, IRQ=1 again DEBOUNCE_CYCLES+3 edges after release.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Interrupt request / acknowledge handshake between the
// button interrupt controller and the core.
interface irq_ctrl_if;
    logic       IRQ;
    logic [4:0] IRQ_ID;
    logic       IRQ_ACK;
    logic [4:0] IRQ_ACK_ID;

    modport master (
        output IRQ,
        output IRQ_ID,
        input  IRQ_ACK,
        input  IRQ_ACK_ID
    );

    modport slave (
        input  IRQ,
        input  IRQ_ID,
        output IRQ_ACK,
        output IRQ_ACK_ID
    );
endinterface

// File: rtl/irq_ctrl.sv
// Four-line button interrupt controller: synchronize, debounce,
// latch rising events as pending, present one at a time to the core.
module irq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [4:0]  IRQ_ID_BASE     = 5'd16
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic [3:0]  BUTTON,
    input  logic [3:0]  ENABLE,
    irq_ctrl_if.master  bus,
    output logic [3:0]  PENDING,
    output logic [3:0]  OVERRUN
);

    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] deb;
    logic [3:0] deb_q;
    logic [7:0] cnt [4];

    state_t     state;
    state_t     state_d;
    logic [1:0] sel;
    logic [1:0] win;
    logic       load;
    logic       ack_hit;
    logic [3:0] req;
    logic [3:0] ev;
    logic [3:0] clr;

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= BUTTON;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i] <= '0;
                    deb[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign ev      = deb & ~deb_q & ENABLE;
    assign req     = PENDING & ENABLE;
    assign ack_hit = (state == ASSERT) && bus.IRQ_ACK
                     && (bus.IRQ_ACK_ID == bus.IRQ_ID);
    assign clr     = ack_hit ? (4'b0001 << sel) : 4'b0000;

    // Lowest enabled pending line wins.
    always_comb begin
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) win = 2'(i);
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_d = ASSERT;
                    load    = 1'b1;
                end
            end
            ASSERT: begin
                if (ack_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state      <= IDLE;
            sel        <= '0;
            bus.IRQ    <= 1'b0;
            bus.IRQ_ID <= '0;
            PENDING    <= '0;
            OVERRUN    <= '0;
        end else begin
            state   <= state_d;
            bus.IRQ <= (state_d == ASSERT);
            if (load) begin
                sel        <= win;
                bus.IRQ_ID <= IRQ_ID_BASE + {3'b000, win};
            end
            // A new event on a line being acknowledged keeps it pending
            // but is not an overrun.
            PENDING <= (PENDING & ~clr) | ev;
            OVERRUN <= (OVERRUN | (ev & PENDING)) & ~clr;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected IDs queued at stimulus
// time, popped on each IRQ rise.
module tb_irq_ctrl;

    logic       CLK = 1'b0;
    logic       RESN;
    logic [3:0] BUTTON;
    logic [3:0] ENABLE;
    logic [3:0] PENDING;
    logic [3:0] OVERRUN;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .IRQ_ID_BASE(5'd16)
    ) dut (
        .CLK(CLK),
        .RESN(RESN),
        .BUTTON(BUTTON),
        .ENABLE(ENABLE),
        .bus(bus),
        .PENDING(PENDING),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] exp_q[$];
    logic       irq_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic ack(input logic [4:0] id);
        bus.IRQ_ACK    = 1'b1;
        bus.IRQ_ACK_ID = id;
        tick();
        bus.IRQ_ACK    = 1'b0;
        bus.IRQ_ACK_ID = '0;
    endtask

    always begin
        @(posedge CLK);
        #1;
        if (bus.IRQ && !irq_prev) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_irq", 32'(exp_q.size()), 1);
            else
                chk("sb_irq_id", 32'(bus.IRQ_ID), 32'(exp_q.pop_front()));
        end
        irq_prev = bus.IRQ;
    end

    initial begin
        BUTTON         = '0;
        ENABLE         = 4'hF;
        bus.IRQ_ACK    = 1'b0;
        bus.IRQ_ACK_ID = '0;
        RESN           = 1'b0;
        tick(2);
        chk("rst_irq", 32'(bus.IRQ), 0);
        chk("rst_id", 32'(bus.IRQ_ID), 0);
        chk("rst_pend", 32'(PENDING), 0);
        chk("rst_ovr", 32'(OVERRUN), 0);
        RESN = 1'b1;
        tick(2);

        // single press latency and ack
        BUTTON = 4'b0001;
        exp_q.push_back(5'd16);
        tick(7);
        chk("lat_edge6", 32'(bus.IRQ), 0);
        tick();
        chk("lat_edge7", 32'(bus.IRQ), 1);
        chk("lat_id", 32'(bus.IRQ_ID), 16);
        chk("lat_pend", 32'(PENDING), 'h1);
        ack(5'd16);
        chk("ack16_irq", 32'(bus.IRQ), 0);
        chk("ack16_pend", 32'(PENDING), 0);
        BUTTON = 4'b0000;
        tick(10);
        chk("fall_pend", 32'(PENDING), 0);

        // glitch shorter than debounce window
        BUTTON = 4'b0001;
        tick(3);
        BUTTON = 4'b0000;
        tick(12);
        chk("glitch_irq", 32'(bus.IRQ), 0);
        chk("glitch_pend", 32'(PENDING), 0);

        // two lines together, priority order
        BUTTON = 4'b0110;
        exp_q.push_back(5'd17);
        exp_q.push_back(5'd18);
        tick(8);
        chk("pri_id17", 32'(bus.IRQ_ID), 17);
        chk("pri_pend", 32'(PENDING), 'h6);
        ack(5'd17);
        chk("pri_gap", 32'(bus.IRQ), 0);
        chk("pri_pend2", 32'(PENDING), 'h4);
        tick();
        chk("pri_irq18", 32'(bus.IRQ), 1);
        chk("pri_id18", 32'(bus.IRQ_ID), 18);
        ack(5'd18);
        chk("pri_end_irq", 32'(bus.IRQ), 0);
        chk("pri_end_pend", 32'(PENDING), 0);
        BUTTON = 4'b0000;
        tick(10);

        // ID held while higher priority arrives; wrong-ID ack ignored
        BUTTON = 4'b0100;
        exp_q.push_back(5'd18);
        tick(8);
        BUTTON = 4'b0101;
        tick(8);
        chk("hold_id", 32'(bus.IRQ_ID), 18);
        chk("hold_pend", 32'(PENDING), 'h5);
        ack(5'd16);
        chk("badack_irq", 32'(bus.IRQ), 1);
        chk("badack_id", 32'(bus.IRQ_ID), 18);
        chk("badack_pend", 32'(PENDING), 'h5);
        exp_q.push_back(5'd16);
        ack(5'd18);
        chk("hold_gap", 32'(bus.IRQ), 0);
        tick();
        chk("hold_next", 32'(bus.IRQ_ID), 16);
        ack(5'd16);
        chk("hold_end_pend", 32'(PENDING), 0);
        BUTTON = 4'b0000;
        tick(10);

        // overrun on second press of line 3
        BUTTON = 4'b1000;
        exp_q.push_back(5'd19);
        tick(8);
        chk("ovr_none", 32'(OVERRUN), 0);
        BUTTON = 4'b0000;
        tick(8);
        BUTTON = 4'b1000;
        tick(8);
        chk("ovr_set", 32'(OVERRUN), 'h8);
        chk("ovr_pend", 32'(PENDING), 'h8);
        chk("ovr_id", 32'(bus.IRQ_ID), 19);
        ack(5'd19);
        chk("ovr_clr", 32'(OVERRUN), 0);
        chk("ovr_pclr", 32'(PENDING), 0);
        chk("ovr_irq", 32'(bus.IRQ), 0);
        BUTTON = 4'b0000;
        tick(10);

        // disabled line never sets pending
        ENABLE = 4'hE;
        BUTTON = 4'b0001;
        tick(10);
        chk("dis_pend", 32'(PENDING), 0);
        chk("dis_irq", 32'(bus.IRQ), 0);
        ENABLE = 4'hF;
        tick(3);
        chk("dis_reen", 32'(PENDING), 0);
        BUTTON = 4'b0000;
        tick(10);

        // new event coincides with its own ack
        BUTTON = 4'b0010;
        exp_q.push_back(5'd17);
        tick(8);
        chk("col_id", 32'(bus.IRQ_ID), 17);
        BUTTON = 4'b0000;
        tick(8);
        BUTTON = 4'b0010;
        tick(6);
        ack(5'd17);
        chk("col_pend", 32'(PENDING), 'h2);
        chk("col_ovr", 32'(OVERRUN), 0);
        chk("col_irq", 32'(bus.IRQ), 0);
        exp_q.push_back(5'd17);
        tick();
        chk("col_reirq", 32'(bus.IRQ), 1);
        ack(5'd17);
        chk("col_end", 32'(PENDING), 0);
        BUTTON = 4'b0000;
        tick(10);

        // enable dropped while presented
        BUTTON = 4'b0001;
        exp_q.push_back(5'd16);
        tick(8);
        ENABLE = 4'h0;
        tick(3);
        chk("endrop_irq", 32'(bus.IRQ), 1);
        chk("endrop_id", 32'(bus.IRQ_ID), 16);
        ack(5'd16);
        chk("endrop_ack", 32'(bus.IRQ), 0);
        ENABLE = 4'hF;
        BUTTON = 4'b0000;
        tick(10);

        // pending but disabled line does not win arbitration
        BUTTON = 4'b1000;
        tick(7);
        ENABLE = 4'h7;
        tick(3);
        chk("masked_irq", 32'(bus.IRQ), 0);
        chk("masked_pend", 32'(PENDING), 'h8);
        ENABLE = 4'hF;
        exp_q.push_back(5'd19);
        tick();
        chk("unmask_irq", 32'(bus.IRQ), 1);
        ack(5'd19);
        BUTTON = 4'b0000;
        tick(10);

        // reset mid-assert with button held
        BUTTON = 4'b0001;
        exp_q.push_back(5'd16);
        tick(8);
        chk("rst2_pre", 32'(bus.IRQ), 1);
        RESN = 1'b0;
        #2;
        chk("rst2_irq", 32'(bus.IRQ), 0);
        chk("rst2_pend", 32'(PENDING), 0);
        tick(2);
        exp_q.push_back(5'd16);
        RESN = 1'b1;
        tick(7);
        chk("rst2_edge6", 32'(bus.IRQ), 0);
        tick();
        chk("rst2_edge7", 32'(bus.IRQ), 1);
        chk("rst2_id", 32'(bus.IRQ_ID), 16);
        ack(5'd16);
        BUTTON = 4'b0000;
        tick(10);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
